// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
//  Module      : stack_unit
//  Description : Hardware LIFO for PSH/POP/CLL/RTN. Pushes on a write strobe,
//                and folds a run of read-enabled cycles into one pop with a
//                registered output word. Sticky overflow/underflow flags.
//  Revision    : 1.0  initial release
// ============================================================================
module stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    input  logic                     stack_en,
    input  logic                     stack_rw,
    input  logic                     stack_rst,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf,
    output logic                     unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  dout_q,  dout_d;
    logic              ovf_q,   ovf_d;
    logic              unf_q,   unf_d;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              is_empty;
    logic              is_full;

    // Occupancy decodes and array indices; count is the next free slot.
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == C_DEPTH);
    assign wr_idx   = AW'(count_q);
    assign rd_idx   = AW'(count_q - CW'(1));

    // Next-state logic: clear beats push beats pop; pop happens only on IDLE entry.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;

        if (stack_rst) begin
            state_d = S_IDLE;
            count_d = '0;
            dout_d  = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (stack_en && stack_rw) begin
            state_d = S_IDLE;
            if (!is_full) begin
                wr_en   = 1'b1;
                count_d = count_q + CW'(1);
            end else begin
                ovf_d   = 1'b1;
            end
        end else if (stack_en) begin
            state_d = S_HOLD;
            if (state_q == S_IDLE) begin
                if (!is_empty) begin
                    dout_d  = mem[rd_idx];
                    count_d = count_q - CW'(1);
                end else begin
                    dout_d  = '0;
                    unf_d   = 1'b1;
                end
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    // Control/status registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array; contents deliberately survive both resets.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_idx] <= din;
        end
    end

    assign dout  = dout_q;
    assign count = count_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_unit
//  Description : Directed self-checking bench for stack_unit with a reference
//                stack model and a scoreboard of expected popped words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stack_unit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    logic              CLK;
    logic              RST_n;
    logic              stack_en;
    logic              stack_rw;
    logic              stack_rst;
    logic [WIDTH-1:0]  din;
    logic [WIDTH-1:0]  dout;
    logic [4:0]        count;
    logic              empty;
    logic              full;
    logic              ovf;
    logic              unf;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             m_ovf;
    logic             m_unf;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .stack_en  (stack_en),
        .stack_rw  (stack_rw),
        .stack_rst (stack_rst),
        .din       (din),
        .dout      (dout),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, settle 1 time unit.
    task automatic cycle(input logic en, input logic rw, input logic rs, input logic [WIDTH-1:0] d);
        stack_en  = en;
        stack_rw  = rw;
        stack_rst = rs;
        din       = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else m_ovf = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, d);
    endtask

    task automatic clear_model();
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(model_q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
        chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
        chk({tag, ".unf"},   32'(unf),   32'(m_unf));
    endtask

    // POP/RTN: en high for EXEC1 and EXEC2, then FETCH idle.
    task automatic pop_pattern(input string tag);
        if (model_q.size() > 0) exp_q.push_back(model_q.pop_back());
        else begin
            exp_q.push_back('0);
            m_unf = 1'b1;
        end
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        chk({tag, ".dout"}, 32'(dout), 32'(exp_q.pop_front()));
        check_status(tag);
        idle(1);
    endtask

    initial begin
        RST_n     = 1'b0;
        stack_en  = 1'b0;
        stack_rw  = 1'b0;
        stack_rst = 1'b0;
        din       = '0;
        clear_model();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset.dout", 32'(dout), 32'h0);
        check_status("reset");
        @(negedge CLK);
        RST_n = 1'b1;
        idle(2);
        check_status("idle");

        // Two pushes with gaps, then two POPs.
        push(16'h1234); idle(2);
        push(16'hBEEF); idle(2);
        check_status("push2");
        pop_pattern("pop_beef");
        pop_pattern("pop_1234");

        // Fill, overflow, pop top.
        for (int i = 0; i < DEPTH; i++) push(WIDTH'(i));
        check_status("filled");
        push(16'hFFFF);
        check_status("ovf_push");
        pop_pattern("pop_after_ovf");

        // Push immediately followed by pop returns the pushed word.
        push(16'h7E57);
        pop_pattern("cll_rtn");

        // Clear, then underflow.
        cycle(1'b0, 1'b0, 1'b1, '0);
        clear_model();
        chk("clr.dout", 32'(dout), 32'h0);
        check_status("clr");
        pop_pattern("pop_empty");
        push(16'h00AA); idle(1);
        pop_pattern("pop_aa");

        // Clear wins over a concurrent push.
        cycle(1'b0, 1'b0, 1'b1, '0);
        clear_model();
        push(16'h0101); push(16'h0202); push(16'h0303);
        check_status("push3");
        cycle(1'b1, 1'b1, 1'b1, 16'h5555);
        clear_model();
        chk("rst_push.dout", 32'(dout), 32'h0);
        check_status("rst_push");
        pop_pattern("pop_after_rst_push");

        // Async reset in the middle of a HOLD with two entries left.
        cycle(1'b0, 1'b0, 1'b1, '0);
        clear_model();
        push(16'hA001); push(16'hA002); push(16'hA003);
        exp_q.push_back(model_q.pop_back());
        cycle(1'b1, 1'b0, 1'b0, '0);
        chk("hold.dout", 32'(dout), 32'(exp_q.pop_front()));
        check_status("hold");
        #2;
        RST_n = 1'b0;
        clear_model();
        #1;
        chk("async.dout", 32'(dout), 32'h0);
        check_status("async");
        @(negedge CLK);
        RST_n = 1'b1;
        exp_q.push_back('0);
        m_unf = 1'b1;
        @(posedge CLK);
        #1;
        chk("fresh_pop.dout", 32'(dout), 32'(exp_q.pop_front()));
        check_status("fresh_pop");
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_unit.md
# stack_unit

Hardware LIFO serving the PSH, POP, CLL and RTN instructions. Sits directly downstream of the instruction decoder and consumes its `stack_en`, `stack_rw` and `stack_rst` strobes. It stores 16-bit words pushed from the datapath (a register value or a return address) and presents the popped word for the EXEC2 register/PC write-back. POP and RTN hold `stack_en` high for both EXEC1 and EXEC2, so the block folds a run of consecutive read-enabled cycles into a single pop.

## Interface
- `WIDTH`, 16, data word width
- `DEPTH`, 16, number of entries (power of two, ≥2)
- `CLK`  in  1  system clock, rising edge
- `RST_n`  in  1  asynchronous active-low reset
- `stack_en`  in  1  access strobe from decoder
- `stack_rw`  in  1  1 = push (write), 0 = pop (read); meaningful only when `stack_en`=1
- `stack_rst`  in  1  synchronous clear (STP); priority over all accesses
- `din`  in  WIDTH  word to push
- `dout`  out  WIDTH  registered popped word
- `count`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
- `empty`  out  1  `count`==0
- `full`  out  1  `count`==DEPTH
- `ovf`  out  1  sticky: push attempted while full
- `unf`  out  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH×WIDTH register array `mem`, index `count` = next free slot. Array contents are not cleared by either reset.
- Two-state read FSM: IDLE, HOLD.
  - IDLE, `stack_en`=1, `stack_rw`=0: pop. If not empty, `dout`<=`mem[count-1]`, `count`<=`count-1`. If empty, `dout`<=0, `count` unchanged, `unf`<=1. Next state HOLD (in both cases).
  - HOLD, `stack_en`=1, `stack_rw`=0: no pop; `dout`, `count` held; stay HOLD.
  - HOLD, `stack_en`=0: return to IDLE, `dout` held.
  - Any state, `stack_en`=1, `stack_rw`=1: push. If not full, `mem[count]`<=`din`, `count`<=`count+1`. If full, write dropped, `count` unchanged, `ovf`<=1. Next state IDLE.
  - `stack_en`=0 in IDLE: no change.
- `stack_rst`=1 (synchronous): `count`<=0, `dout`<=0, `ovf`<=0, `unf`<=0, state IDLE; concurrent access ignored.
- `ovf`/`unf` clear only on `RST_n` or `stack_rst`.
- `empty`/`full` are combinational decodes of `count`.
- Arithmetic: `count` never wraps; saturation is enforced by the full/empty guards above, not by modulo arithmetic.

## Timing
- `RST_n` low: immediately `count`=0, `dout`=0, `ovf`=0, `unf`=0, state IDLE, so `empty`=1 and `full`=0.
- Push: `din` sampled at the edge ending the EXEC1 cycle; `count` and `full` update after that edge.
- Pop latency is one cycle. An EXEC1 pop edge makes `dout` valid throughout EXEC2, and `dout` stays stable until the next pop or clear.
- POP/RTN (en high across EXEC1 and EXEC2) decrements `count` exactly once. Back-to-back POPs are separated by FETCH (`stack_en`=0), so each performs its own pop.
- A push immediately followed by a pop (CLL then RTN) returns the pushed word.
- Reset asserted mid-HOLD: FSM to IDLE. The next read-enabled cycle is a fresh pop.

## Test plan
- Reset then idle: `count`=0, `empty`=1, `full`=0, `dout`=0, `ovf`=`unf`=0.
- Push 0x1234, 0xBEEF (one cycle each, gaps of 2 idle cycles), then POP pattern (en=1 rw=0 for 2 cycles, then 1 idle): `dout`=0xBEEF in cycle 2 and `count`=1. Second POP pattern: `dout`=0x1234, `count`=0, `empty`=1.
- Push DEPTH words 0x0000..0x000F: `full`=1, `count`=16. 17th push of 0xFFFF: `count` stays 16, `ovf`=1. Pop returns 0x000F, not 0xFFFF.
- POP pattern while empty: `dout`=0, `unf`=1, `count`=0. A subsequent push of 0x00AA, then pop, gives 0x00AA with `unf` still 1.
- Push 3 words, then assert `stack_rst` together with a push of 0x5555: `count`=0, flags 0, `dout`=0. A following pop sets `unf`=1, confirming nothing was written.
- Assert `RST_n` low mid-HOLD with `count`=2: outputs go to reset values asynchronously. After release, the first read-enabled cycle pops, giving `unf`=1 and `dout`=0.
